// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the CPU control sequencer.
//   - ALU opcode constants (shared with the ALU)
//   - sequencer state encoding
//   - IR field bit positions
//   - opcode classification helpers
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    // Two-operand ops whose result is a single Z-low write to Ra.
    function automatic logic op_is_alu2(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Single-operand ops: the second ALU operand comes from Rb, not Rc.
    function automatic logic op_is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic op_is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Anything that goes through T3..T5; the rest (NOP, undefined) ends in T2.
    function automatic logic op_is_exec(input logic [4:0] op);
        return op_is_alu2(op) || op_is_unary(op) || op_is_muldiv(op);
    endfunction

endpackage

// File: rtl/ir_field_decoder.sv
// ir_field_decoder: 4-to-16 one-hot decoder with enable.
// Ports:
//   sel    in  4   register index from an IR field
//   en     in  1   decoder enable; output is all-zero when low
//   onehot out 16  bit[sel] set when enabled
module ir_field_decoder (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] onehot
);

    assign onehot = en ? (16'h0001 << sel) : 16'h0000;

endmodule

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: Moore T-state control sequencer for the single-bus
// CPU datapath. Fetches an instruction through MAR/MDR/IR with a mem_ready
// handshake, then executes register-format ALU, MUL/DIV, NOP and HALT.
// Ports:
//   clk, clr (async active-low reset)
//   IR_data_in  32  current IR contents (opcode, Ra, Rb, Rc)
//   mem_ready    1  memory read data valid (sampled only in T1)
//   PCout/MDRout/ZLowout/ZHighout, R_out[15:0]  bus source selects
//   MARin/IncPC/Read/MDRin/IRin/Yin/ZLowIn/ZHighIn/HIin/LOin, R_in[15:0]
//   operation    5  ALU opcode (valid in T4 only)
//   run, instr_done
//   fault        1  memory timeout flag (CTRL_MEM_TIMEOUT_EN only)
// Optional feature macro: CTRL_MEM_TIMEOUT_EN -- bounds the T1 wait to
// MEM_TIMEOUT cycles, then halts with a sticky fault.
module cpu_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_data_in,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Read,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] R_out,
    output logic [15:0] R_in,
    output logic [4:0]  operation,
    output logic        run,
`ifdef CTRL_MEM_TIMEOUT_EN
    output logic        fault,
`endif
    output logic        instr_done
);

    state_t state, nxt;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       ir_unused;

    assign opcode    = IR_data_in[OPC_MSB:OPC_LSB];
    assign ra        = IR_data_in[RA_MSB:RA_LSB];
    assign rb        = IR_data_in[RB_MSB:RB_LSB];
    assign rc        = IR_data_in[RC_MSB:RC_LSB];
    assign ir_unused = ^IR_data_in[RC_LSB-1:0];

    logic timeout;

`ifdef CTRL_MEM_TIMEOUT_EN
    // Counts cycles spent in T1; held at zero in every other state so it
    // restarts on each T1 entry.
    logic [4:0] wait_cnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)               wait_cnt <= '0;
        else if (state != ST_T1) wait_cnt <= '0;
        else                    wait_cnt <= wait_cnt + 5'd1;
    end

    // Fires in the MEM_TIMEOUT-th T1 cycle if memory still has not answered.
    assign timeout = (state == ST_T1) && !mem_ready &&
                     (wait_cnt == 5'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)         fault <= 1'b0;
        else if (timeout) fault <= 1'b1;
    end
`else
    localparam int TIMEOUT_unused = MEM_TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= ST_RESET;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_RESET: nxt = ST_T0;
            ST_T0:    nxt = ST_T1;
            ST_T1: begin
                if (mem_ready)    nxt = ST_T2;
                else if (timeout) nxt = ST_HALT;
            end
            ST_T2: begin
                if (opcode == OP_HALT)   nxt = ST_HALT;
                else if (op_is_exec(opcode)) nxt = ST_T3;
                else                     nxt = ST_T0;
            end
            ST_T3:   nxt = ST_T4;
            ST_T4:   nxt = ST_T5;
            ST_T5:   nxt = op_is_muldiv(opcode) ? ST_T6 : ST_T0;
            ST_T6:   nxt = ST_T0;
            ST_HALT: nxt = ST_HALT;
            default: nxt = ST_RESET;
        endcase
    end

    // Register selects come from the three field decoders; their enables
    // are the only state-dependent part.
    logic        ra_en, rb_en, rc_en;
    logic [15:0] ra_oh, rb_oh, rc_oh;

    always_comb begin
        PCout     = 1'b0;
        MDRout    = 1'b0;
        ZLowout   = 1'b0;
        ZHighout  = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        ZLowIn    = 1'b0;
        ZHighIn   = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        operation = 5'd0;
        instr_done = 1'b0;
        ra_en     = 1'b0;
        rb_en     = 1'b0;
        rc_en     = 1'b0;
        run       = (state != ST_RESET) && (state != ST_HALT);
        case (state)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                instr_done = (opcode != OP_HALT) && !op_is_exec(opcode);
            end
            ST_T3: begin
                rb_en = 1'b1;
                Yin   = 1'b1;
            end
            ST_T4: begin
                rb_en     = op_is_unary(opcode);
                rc_en     = !op_is_unary(opcode);
                operation = opcode;
                ZLowIn    = 1'b1;
                ZHighIn   = 1'b1;
            end
            ST_T5: begin
                ZLowout = 1'b1;
                if (op_is_muldiv(opcode)) begin
                    LOin = 1'b1;
                end else begin
                    ra_en      = 1'b1;
                    instr_done = 1'b1;
                end
            end
            ST_T6: begin
                ZHighout   = 1'b1;
                HIin       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    ir_field_decoder u_dec_ra (.sel(ra), .en(ra_en), .onehot(ra_oh));
    ir_field_decoder u_dec_rb (.sel(rb), .en(rb_en), .onehot(rb_oh));
    ir_field_decoder u_dec_rc (.sel(rc), .en(rc_en), .onehot(rc_oh));

    // R0 is a read-only zero source: writes targeting it are dropped.
    assign R_in  = ra_oh & 16'hFFFE;
    assign R_out = rb_oh | rc_oh;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Testbench for cpu_control_sequencer: scripted and random instructions
// checked cycle by cycle against a per-instruction expected control trace.
module tb_cpu_control_sequencer;

    logic        clk, clr, mem_ready;
    logic [31:0] IR_data_in;
    logic        PCout, MDRout, ZLowout, ZHighout, MARin, IncPC, Read, MDRin;
    logic        IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, run, instr_done;
    logic [15:0] R_out, R_in;
    logic [4:0]  operation;
`ifdef CTRL_MEM_TIMEOUT_EN
    logic        fault;
`endif

    cpu_control_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .clr(clr), .IR_data_in(IR_data_in), .mem_ready(mem_ready),
        .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .ZHighout(ZHighout),
        .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
        .R_out(R_out), .R_in(R_in), .operation(operation), .run(run),
`ifdef CTRL_MEM_TIMEOUT_EN
        .fault(fault),
`endif
        .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pcout, mdrout, zlowout, zhighout;
        logic        marin, incpc, read, mdrin, irin, yin;
        logic        zlowin, zhighin, hiin, loin;
        logic [15:0] r_out, r_in;
        logic [4:0]  operation;
        logic        run, done;
    } ctl_t;

    int   n_cmp = 0;
    int   n_err = 0;
    ctl_t exp_q[$];
    bit   mr_q[$];

    function automatic ctl_t obs();
        ctl_t o;
        o = '{PCout, MDRout, ZLowout, ZHighout, MARin, IncPC, Read, MDRin, IRin,
              Yin, ZLowIn, ZHighIn, HIin, LOin, R_out, R_in, operation, run,
              instr_done};
        return o;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input int a,
                                          input int b, input int c);
        return {op, 4'(a), 4'(b), 4'(c), 15'h0};
    endfunction

    task automatic push(input ctl_t c, input bit mr);
        exp_q.push_back(c);
        mr_q.push_back(mr);
    endtask

    // Expected per-cycle control trace for one instruction, from the
    // instruction's class and the number of memory wait cycles.
    task automatic build_instr(input logic [31:0] ir, input int waits);
        ctl_t       c;
        logic [4:0] op;
        int         a, b, cc;
        bit         alu2, unary, muldiv, halt, exec;
        op = ir[31:27];
        a = int'(ir[26:23]); b = int'(ir[22:19]); cc = int'(ir[18:15]);
        alu2   = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
        unary  = op inside {5'd17, 5'd18};
        muldiv = op inside {5'd15, 5'd16};
        halt   = (op == 5'd27);
        exec   = alu2 || unary || muldiv;
        c = '0; c.run = 1; c.pcout = 1; c.marin = 1; c.incpc = 1;
        push(c, 1'($urandom_range(0, 1)));
        for (int i = 0; i <= waits; i++) begin
            c = '0; c.run = 1; c.read = 1; c.mdrin = 1;
            push(c, i == waits);
        end
        c = '0; c.run = 1; c.mdrout = 1; c.irin = 1; c.done = !exec && !halt;
        push(c, 1'($urandom_range(0, 1)));
        if (exec) begin
            c = '0; c.run = 1; c.yin = 1; c.r_out = 16'(1) << b;
            push(c, 1'($urandom_range(0, 1)));
            c = '0; c.run = 1; c.zlowin = 1; c.zhighin = 1; c.operation = op;
            c.r_out = 16'(1) << (unary ? b : cc);
            push(c, 1'($urandom_range(0, 1)));
            c = '0; c.run = 1; c.zlowout = 1;
            if (muldiv) c.loin = 1;
            else begin
                c.done = 1;
                c.r_in = (a == 0) ? 16'h0 : (16'(1) << a);
            end
            push(c, 1'($urandom_range(0, 1)));
            if (muldiv) begin
                c = '0; c.run = 1; c.zhighout = 1; c.hiin = 1; c.done = 1;
                push(c, 1'($urandom_range(0, 1)));
            end
        end
    endtask

    // Entered #1 after a rising edge; plays up to max_cyc queued cycles
    // (all when negative), checking outputs at each falling edge.
    task automatic play(input string name, input int max_cyc);
        ctl_t e, o;
        int   cyc = 0;
        while (exp_q.size() > 0 && (max_cyc < 0 || cyc < max_cyc)) begin
            mem_ready = mr_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s cyc %0d: got %h expected %h", name, cyc, o, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input string name, input logic [31:0] ir, input int waits);
        IR_data_in = ir;
        build_instr(ir, waits);
        play(name, -1);
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (obs() !== ctl_t'(0)) begin
            n_err++;
            $display("FAIL %s: got %h expected 0", name, obs());
        end
    endtask

    // Asserts clr, checks the asynchronous drop, releases it and checks the
    // single RESET cycle. Returns #1 after the edge that enters T0.
    task automatic do_reset(input string name);
        clr = 0; #1;
        check_zero({name, "_async"});
        @(posedge clk); #1;
        clr = 1;
        @(negedge clk);
        check_zero({name, "_reset_cycle"});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr = 0; mem_ready = 1; IR_data_in = '0;
        repeat (2) @(posedge clk);
        do_reset("reset");
    endtask

    task automatic test_add();
        run_instr("add_r1_r2_r3", 32'h1891_8000, 0);
        run_instr("add_r1_r2_r3_again", mk_ir(5'd3, 1, 2, 3), 0);
    endtask

    task automatic test_mul();
        run_instr("mul_r0_r6_r7", 32'h7833_8000, 0);
        run_instr("div_r5_r9_r4", mk_ir(5'd16, 5, 9, 4), 1);
    endtask

    task automatic test_mem_wait();
        run_instr("add_wait4", 32'h1891_8000, 4);
        run_instr("nop_wait2", mk_ir(5'd26, 3, 4, 5), 2);
        run_instr("neg_r7_r8", mk_ir(5'd17, 7, 8, 15), 0);
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd3;
            run_instr("random_instr",
                      mk_ir(op, $urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 15)),
                      $urandom_range(0, 3));
        end
    endtask

    task automatic test_clr_mid();
        IR_data_in = 32'h1891_8000;
        build_instr(IR_data_in, 0);
        play("clr_mid_pre", 4);
        exp_q.delete(); mr_q.delete();
        n_cmp++;
        if (operation !== 5'd3 || ZLowIn !== 1'b1) begin
            n_err++;
            $display("FAIL clr_mid_t4: got op %0d zlowin %b expected op 3 zlowin 1",
                     operation, ZLowIn);
        end
        do_reset("clr_mid");
        run_instr("clr_mid_resume", mk_ir(5'd5, 12, 13, 14), 0);
    endtask

    task automatic test_halt();
        ctl_t z = '0;
        IR_data_in = 32'hD800_0000;
        build_instr(IR_data_in, 1);
        for (int i = 0; i < 100; i++) push(z, 1'($urandom_range(0, 1)));
        play("halt", -1);
        do_reset("halt_recover");
        run_instr("after_halt", mk_ir(5'd18, 2, 11, 0), 0);
    endtask

`ifdef CTRL_MEM_TIMEOUT_EN
    task automatic test_timeout();
        ctl_t c;
        do_reset("timeout_reset");
        n_cmp++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL fault_after_reset: got %b expected 0", fault);
        end
        IR_data_in = mk_ir(5'd3, 1, 2, 3);
        c = '0; c.run = 1; c.pcout = 1; c.marin = 1; c.incpc = 1; push(c, 1'b0);
        for (int i = 0; i < 16; i++) begin
            c = '0; c.run = 1; c.read = 1; c.mdrin = 1; push(c, 1'b0);
        end
        for (int i = 0; i < 10; i++) push(ctl_t'(0), 1'($urandom_range(0, 1)));
        play("timeout", -1);
        n_cmp++;
        if (fault !== 1'b1) begin
            n_err++;
            $display("FAIL fault_sticky: got %b expected 1", fault);
        end
        clr = 0; #1;
        n_cmp++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL fault_clear: got %b expected 0", fault);
        end
        @(posedge clk); #1;
        clr = 1;
        @(posedge clk); #1;
        run_instr("after_timeout", mk_ir(5'd9, 4, 5, 6), 0);
    endtask
`endif

    initial begin
        clk = 0; clr = 0; mem_ready = 0; IR_data_in = '0;
        test_reset();
        test_add();
        test_mul();
        test_mem_wait();
        test_random();
        test_clr_mid();
        test_halt();
`ifdef CTRL_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
